sr_drive_ctrl: RTL

Command-side controller for a bank of external SR storage cells. It accepts set/clear requests over a valid/ready handshake and drives the selected channel's S or R input for a programmable pulse width. It then watches that channel's Q feedback and reports completion or timeout. It sits between a register/command interface and the SR cell array, so upstream logic never toggles S/R directly.

---
 rtl/sr_drive_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/sr_drive_ctrl.sv
// Set/clear controller for a bank of external SR cells: one request at a time,
// pulses S or R on the selected channel, then watches Q for completion or timeout.
module sr_drive_ctrl #(
    parameter int CHANNELS     = 8,
    parameter int IDX_W        = 3,
    parameter int PULSE_CYCLES = 1,
    parameter int TIMEOUT      = 15,
    parameter int TO_W         = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_idx,
    input  logic                req_val,
    output logic [CHANNELS-1:0] s_out,
    output logic [CHANNELS-1:0] r_out,
    input  logic [CHANNELS-1:0] q_in,
    output logic                done,
    output logic                err,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT
    } state_t;

    localparam logic [IDX_W:0]  CH_LIMIT     = (IDX_W + 1)'(CHANNELS);
    localparam logic [TO_W-1:0] PULSE_LAST   = TO_W'(PULSE_CYCLES - 1);
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              val, val_nx;
    logic [TO_W-1:0]   cnt, cnt_nx;
    logic              done_nx, err_nx;
    logic [CHANNELS-1:0] onehot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            val   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            val   <= val_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

    // The same counter times the pulse and the wait; it is cleared on every state entry.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        val_nx   = val;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    idx_nx = req_idx;
                    val_nx = req_val;
                    cnt_nx = '0;
                    if ({1'b0, req_idx} >= CH_LIMIT) begin
                        err_nx = 1'b1;
                    end else if (q_in[req_idx] == req_val) begin
                        state_nx = WAIT;
                    end else begin
                        state_nx = PULSE;
                    end
                end
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT: begin
                // A match on the last allowed cycle still counts as success.
                if (q_in[idx] == val) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign onehot    = CHANNELS'(1) << idx;
    assign s_out     = (state == PULSE && val)  ? onehot : '0;
    assign r_out     = (state == PULSE && !val) ? onehot : '0;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule
